// File: rtl/ssd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scan_ctrl
//
// Time-multiplexing scan controller for a multi-digit seven-segment display.
// One digit is lit per slot of TICK_DIV clocks. The first GUARD_CYCLES clocks
// of every slot keep all anodes off, so the previous digit's cathode pattern
// cannot ghost onto the next anode. The displayed image is double-buffered:
// new images land in a pending buffer through a valid/ready handshake and are
// copied into the active buffer only at a frame boundary. In IDLE they are
// copied on the cycle after the load, so the display never tears.
//
// Build option:
//   SSD_LEADING_ZERO_BLANK_EN - when defined, digits k > 0 whose nibble and
//                               all higher nibbles are zero show no segments.
//                               Digit 0 always shows. The decimal point is
//                               unaffected.
//
// Parameters:
//   NUM_DIGITS   - digits scanned; digit k drives an[k]
//   TICK_DIV     - clocks per digit slot (>= 2)
//   GUARD_CYCLES - blanked clocks at the start of each slot (< TICK_DIV)
//
// Ports:
//   clk        in   master clock
//   reset      in   asynchronous, active-high reset
//   enable     in   scan enable; low blanks the display and parks in IDLE
//   load_valid in   new image offered
//   load_data  in   hex nibbles, digit k = load_data[4k+3:4k]
//   load_dp    in   decimal point per digit, 1 = lit
//   load_ready out  pending buffer empty; load taken on valid && ready
//   an         out  anodes, active-low
//   seg        out  cathodes {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   frame_done out  one-cycle pulse with the last cycle of the last slot
// ---------------------------------------------------------------------------
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic                    load_ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] G_LAST = (GUARD_CYCLES > 0) ? PW'(GUARD_CYCLES - 1) : '0;
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // A slot opens in GUARD unless there is no guard time at all.
  localparam state_t ST_SLOT = (GUARD_CYCLES > 0) ? ST_GUARD : ST_DRIVE;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t                  r_state;
  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_full;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_done;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  state_t                  w_state_nxt;
  logic                    w_accept;
  logic                    w_boundary;
  logic                    w_swap;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_digit_blank;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;

  assign w_accept   = load_valid && !r_pend_full;
  assign w_boundary = (r_state == ST_DRIVE) && (r_idx == I_LAST) && (r_presc == P_LAST);
  // Both are gated by pending-full, so an accept and a swap never coincide:
  // a load taken in the boundary cycle waits for the following boundary.
  assign w_swap     = r_pend_full && (w_boundary || (r_state == ST_IDLE));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks run in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can hold a
  // previous value and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_SLOT;
        ST_GUARD: if (r_presc == G_LAST) w_state_nxt = ST_DRIVE;
        ST_DRIVE: if (r_presc == P_LAST) w_state_nxt = ST_SLOT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Prescaler and digit index: cleared whenever the scan is parked.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (!enable || (r_state == ST_IDLE)) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == P_LAST) begin
      r_presc <= '0;
      r_idx   <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Double-buffered image
  // -------------------------------------------------------------------------
  // NOTE: both image buffers are reset on purpose: a reset must blank the
  // display and discard the old image, not leave stale digits behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_data  <= '0;
      r_act_dp    <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
    end else begin
      if (w_swap) begin
        r_act_data  <= r_pend_data;
        r_act_dp    <= r_pend_dp;
        r_pend_full <= 1'b0;
      end
      if (w_accept) begin
        r_pend_data <= load_data;
        r_pend_dp   <= load_dp;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign load_ready = !r_pend_full;

  // -------------------------------------------------------------------------
  // Digit select from the active image
  // -------------------------------------------------------------------------
  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib    = r_act_data[4*k +: 4];
        w_dp_sel = r_act_dp[k];
      end
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // w_lz[k] is set when nibbles k..NUM_DIGITS-1 are all zero; digit 0 is
  // never a leading zero.
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_zero_run;

  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zero_run = w_zero_run && (r_act_data[4*k +: 4] == 4'h0);
      w_lz[k]    = w_zero_run;
    end
  end

  assign w_digit_blank = w_lz[r_idx];
`else
  assign w_digit_blank = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: output logic
  // -------------------------------------------------------------------------
  // Enable is looked at directly, so dropping it blanks the pins one cycle
  // later rather than two.
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if (enable && (r_state == ST_DRIVE)) begin
      w_an_nxt[r_idx] = 1'b0;
      w_seg_nxt       = w_digit_blank ? 7'h7F : hex7(w_nib);
      w_dp_nxt        = !w_dp_sel;
    end
  end

  // Output registers. frame_done is registered with the pins so that it
  // lines up with the last visible cycle of the last digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an         <= '1;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule
